// File: rtl/shift_latch_receiver.sv
// Receiver for the three-wire shift/latch/data link: synchronises the wires, deserialises, latches words.
// Optional macro SHIFT_LATCH_RX_STRICT_EN rejects latches whose shift count differs from WIDTH.
module shift_latch_receiver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             shift,
    input  logic             latch,
    input  logic             data,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [3:0]       bit_count,
    output logic             frame_err
);
    localparam logic [3:0] CNT_SAT = 4'(WIDTH + 1);

    logic [SYNC_STAGES-1:0] shift_sync;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   shift_hist;
    logic                   latch_hist;
    logic                   shift_rise;
    logic                   latch_rise;
    logic [WIDTH-1:0]       sreg;
    logic [WIDTH-1:0]       sreg_next;
    logic [3:0]             count_next;

    // data shares the control wires' sync depth so it stays aligned with the shift edge
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            shift_sync <= '0;
            latch_sync <= '0;
            data_sync  <= '0;
            shift_hist <= 1'b0;
            latch_hist <= 1'b0;
        end else begin
            shift_sync <= {shift_sync[SYNC_STAGES-2:0], shift};
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], data};
            shift_hist <= shift_sync[SYNC_STAGES-1];
            latch_hist <= latch_sync[SYNC_STAGES-1];
        end
    end

    // Post-shift values, so a latch in the same cycle as a shift sees the shifted word and count
    always_comb begin
        shift_rise = shift_sync[SYNC_STAGES-1] & ~shift_hist;
        latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_hist;
        sreg_next  = sreg;
        count_next = bit_count;
        if (shift_rise) begin
            sreg_next = {data_sync[SYNC_STAGES-1], sreg[WIDTH-1:1]};
            if (bit_count != CNT_SAT) begin
                count_next = bit_count + 4'd1;
            end
        end
    end

`ifdef SHIFT_LATCH_RX_STRICT_EN
    localparam logic [3:0] CNT_FULL = 4'(WIDTH);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sreg      <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            bit_count <= '0;
            frame_err <= 1'b0;
        end else begin
            sreg      <= sreg_next;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            if (latch_rise) begin
                bit_count <= '0;
                if (count_next == CNT_FULL) begin
                    q       <= sreg_next;
                    q_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else begin
                bit_count <= count_next;
            end
        end
    end
`else
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sreg      <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            bit_count <= '0;
        end else begin
            sreg    <= sreg_next;
            q_valid <= 1'b0;
            if (latch_rise) begin
                bit_count <= '0;
                q         <= sreg_next;
                q_valid   <= 1'b1;
            end else begin
                bit_count <= count_next;
            end
        end
    end

    assign frame_err = 1'b0;
`endif

endmodule
